// File: rtl/key_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_pkg: shared state encoding and defaults for key_event_decoder     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS1 = 2'd1,
    ST_WAIT2  = 2'd2,
    ST_HOLD   = 2'd3
  } key_state_e;

  localparam int unsigned C_CLK_FREQ_DEF  = 50_000_000;
  localparam int unsigned C_LONG_MS_DEF   = 1000;
  localparam int unsigned C_DOUBLE_MS_DEF = 300;
  localparam int unsigned C_MS_CNT_W      = 11;
  localparam int unsigned C_NUM_KEYS      = 3;

endpackage
`default_nettype wire

// File: rtl/key_event_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_event_ch: per-key click / double-click / long-press classifier    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module key_event_ch
  import key_pkg::*;
#(
  parameter int unsigned LONG_MS   = C_LONG_MS_DEF,
  parameter int unsigned DOUBLE_MS = C_DOUBLE_MS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ms_tick,
  input  logic key_level,
  output logic key_click,
  output logic key_dclick,
  output logic key_long
);

  localparam logic [C_MS_CNT_W-1:0] C_LONG_LAST   = C_MS_CNT_W'(LONG_MS - 1);
  localparam logic [C_MS_CNT_W-1:0] C_DOUBLE_LAST = C_MS_CNT_W'(DOUBLE_MS - 1);

  key_state_e            state_q, state_d;
  logic [C_MS_CNT_W-1:0] cnt_q, cnt_d;
  logic                  key_prev_q;
  logic                  click_q, click_d;
  logic                  dclick_q, dclick_d;
  logic                  long_q, long_d;
  logic                  press_edge;

  assign press_edge = key_level & ~key_prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_edge) begin
          state_d = ST_PRESS1;
          cnt_d   = '0;
        end
      end
      // Release is checked first so it wins over a coincident long expiry.
      ST_PRESS1: begin
        if (!key_level) begin
          state_d = ST_WAIT2;
          cnt_d   = '0;
        end else if (ms_tick) begin
          if (cnt_q == C_LONG_LAST) begin
            long_d  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // A second press wins over a coincident gap timeout.
      ST_WAIT2: begin
        if (key_level) begin
          dclick_d = 1'b1;
          state_d  = ST_HOLD;
        end else if (ms_tick) begin
          if (cnt_q == C_DOUBLE_LAST) begin
            click_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!key_level) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // key_prev resets high so a key held through reset needs a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      key_prev_q <= 1'b1;
      click_q    <= 1'b0;
      dclick_q   <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_prev_q <= key_level;
      click_q    <= click_d;
      dclick_q   <= dclick_d;
      long_q     <= long_d;
    end
  end

  assign key_click  = click_q;
  assign key_dclick = dclick_q;
  assign key_long   = long_q;

endmodule
`default_nettype wire

// File: rtl/key_event_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_event_decoder: shared ms tick plus three independent key channels |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = C_CLK_FREQ_DEF,
  parameter int unsigned LONG_MS   = C_LONG_MS_DEF,
  parameter int unsigned DOUBLE_MS = C_DOUBLE_MS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [C_NUM_KEYS-1:0] key_level,
  output logic [C_NUM_KEYS-1:0] key_click,
  output logic [C_NUM_KEYS-1:0] key_dclick,
  output logic [C_NUM_KEYS-1:0] key_long
);

  // Clocks below 2 kHz degenerate to a tick every cycle.
  localparam int unsigned C_TICK_DIV = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 1;
  localparam int unsigned C_TICK_W   = (C_TICK_DIV > 1) ? $clog2(C_TICK_DIV) : 1;
  localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(C_TICK_DIV - 1);

  logic [C_TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic                ms_tick;

  assign ms_tick = (tick_cnt_q == C_TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (ms_tick) begin
      tick_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < C_NUM_KEYS; i++) begin : g_ch
    key_event_ch #(
      .LONG_MS   (LONG_MS),
      .DOUBLE_MS (DOUBLE_MS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .ms_tick    (ms_tick),
      .key_level  (key_level[i]),
      .key_click  (key_click[i]),
      .key_dclick (key_dclick[i]),
      .key_long   (key_long[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_key_event_decoder: directed scoreboard bench for key_event_decoder |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_key_event_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] key_level;
  logic [2:0] key_click, key_dclick, key_long;

  key_event_decoder #(
    .CLK_FREQ  (10_000),
    .LONG_MS   (20),
    .DOUBLE_MS (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_level  (key_level),
    .key_click  (key_click),
    .key_dclick (key_dclick),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [8:0]  vec;
  } exp_t;

  exp_t        sb[$];
  int unsigned gcyc = 0;
  int unsigned tcyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_v, obs_v;

  // gcyc timestamps events; tcyc tracks the ms tick phase (tick when tcyc%10==9).
  always @(posedge clk) gcyc <= gcyc + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcyc <= 0;
    else        tcyc <= tcyc + 1;
  end

  // Vector layout: {long[2:0], dclick[2:0], click[2:0]}.
  always @(negedge clk) begin
    exp_v = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == gcyc) begin
        exp_v = exp_v | sb[i].vec;
        sb.delete(i);
      end
    end
    obs_v = {key_long, key_dclick, key_click};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL events cyc=%0d observed=%b expected=%b", gcyc, obs_v, exp_v);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic align0();
    while (tcyc % 10 != 0) step(1);
  endtask

  task automatic expect_ev(input int unsigned at, input logic [8:0] v);
    exp_t e;
    e.cyc = at;
    e.vec = v;
    sb.push_back(e);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_level = 3'b000;
    step(3);
    checks++;
    assert ({key_long, key_dclick, key_click} === 9'd0) else begin
      errors++;
      $error("FAIL reset_state observed=%b expected=%b", {key_long, key_dclick, key_click}, 9'd0);
    end
    rst_n = 1'b1;
    step(5);

    // Single click on key0: release at tick phase 0, click 5 ticks later.
    align0();
    key_level = 3'b001;
    step(50);
    key_level = 3'b000;
    expect_ev(gcyc + 50, 9'b000_000_001);
    step(60);

    // Double click on key1, then a long hold yields nothing more.
    align0();
    key_level = 3'b010;
    step(3);
    key_level = 3'b000;
    step(17);
    key_level = 3'b010;
    expect_ev(gcyc + 1, 9'b000_010_000);
    step(300);
    key_level = 3'b000;
    step(60);

    // Long press on key2 at the 20th tick, release is silent.
    align0();
    key_level = 3'b100;
    expect_ev(gcyc + 200, 9'b100_000_000);
    step(250);
    key_level = 3'b000;
    step(100);

    // key0 held through reset: no events until a fresh press.
    key_level = 3'b001;
    rst_n     = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(300);
    key_level = 3'b000;
    step(5);
    align0();
    key_level = 3'b001;
    step(10);
    key_level = 3'b000;
    expect_ev(gcyc + 50, 9'b000_000_001);
    step(60);

    // Release coincides with the long-expiry tick; re-press on the timeout tick.
    align0();
    key_level = 3'b001;
    step(199);
    key_level = 3'b000;
    step(50);
    key_level = 3'b001;
    expect_ev(gcyc + 1, 9'b000_000_001 << 3);
    step(20);
    key_level = 3'b000;
    step(20);

    // key0 in WAIT2 and key1 held when reset hits: everything abandoned.
    align0();
    key_level = 3'b011;
    step(3);
    key_level = 3'b010;
    step(20);
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({key_long, key_dclick, key_click} === 9'd0) else begin
      errors++;
      $error("FAIL async_reset observed=%b expected=%b", {key_long, key_dclick, key_click}, 9'd0);
    end
    step(3);
    key_level = 3'b000;
    rst_n     = 1'b1;
    step(300);
    align0();
    key_level = 3'b001;
    step(10);
    key_level = 3'b000;
    expect_ev(gcyc + 50, 9'b000_000_001);
    step(60);

    // Simultaneous clicks on key0 and key2 report in the same cycle.
    align0();
    key_level = 3'b101;
    step(10);
    key_level = 3'b000;
    expect_ev(gcyc + 50, 9'b000_000_101);
    step(60);

    step(5);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL pending_events observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
